// File: rtl/traffic_light_controller_multi.sv
// Round-robin traffic light controller for NUM_DIR approaches with an internal
// countdown timer, pedestrian walk phase (with early green cut) and night flash mode.
module traffic_light_controller_multi #(
  parameter int NUM_DIR   = 2,
  parameter int TIMER_W   = 8,
  parameter int GREEN_T   = 20,
  parameter int MIN_GREEN = 5,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10,
  parameter int FLASH_T   = 8,
  localparam int PW = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ped_req,
  input  logic               flash_en,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic               walk,
  output logic               ped_pending,
  output logic [PW-1:0]      phase_idx
);

  localparam longint TLIM = 64'd1 << TIMER_W;

  if (MIN_GREEN > GREEN_T || MIN_GREEN < 1 || GREEN_T < 1 || YELLOW_T < 1 ||
      ALLRED_T < 1 || WALK_T < 1 || FLASH_T < 1) begin : g_bad_duration
    $error("traffic_light_controller_multi: invalid duration parameters");
  end
  if (GREEN_T >= TLIM || YELLOW_T >= TLIM || ALLRED_T >= TLIM ||
      WALK_T >= TLIM || FLASH_T >= TLIM) begin : g_bad_width
    $error("traffic_light_controller_multi: duration does not fit TIMER_W");
  end
  if (NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_dirs
    $error("traffic_light_controller_multi: NUM_DIR must be 2..8");
  end

  localparam logic [TIMER_W-1:0] GREEN_LAST = TIMER_W'(GREEN_T - 1);
  localparam logic [TIMER_W-1:0] MIN_LAST   = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LD  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LD  = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] WALK_LD    = TIMER_W'(WALK_T - 1);
  localparam logic [TIMER_W-1:0] FLASH_LD   = TIMER_W'(FLASH_T - 1);
  localparam logic [PW-1:0]      LAST_PHASE = PW'(NUM_DIR - 1);

  typedef enum logic [2:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_WALK, S_FLASH} state_t;

  state_t               state_reg, state_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [TIMER_W-1:0]   elapsed_reg, elapsed_next;
  logic [PW-1:0]        phase_reg, phase_next;
  logic                 ped_pending_reg, ped_pending_next;
  logic                 from_walk_reg, from_walk_next;
  logic                 flash_on_reg, flash_on_next;
  logic                 timer_done;
  logic                 enter_walk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_ALL_RED;
      timer_reg       <= ALLRED_LD;
      elapsed_reg     <= '0;
      phase_reg       <= '0;
      ped_pending_reg <= 1'b0;
      from_walk_reg   <= 1'b0;
      flash_on_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      elapsed_reg     <= elapsed_next;
      phase_reg       <= phase_next;
      ped_pending_reg <= ped_pending_next;
      from_walk_reg   <= from_walk_next;
      flash_on_reg    <= flash_on_next;
    end
  end

  assign timer_done = (timer_reg == '0);

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_done ? timer_reg : timer_reg - TIMER_W'(1);
    elapsed_next   = elapsed_reg;
    phase_next     = phase_reg;
    from_walk_next = from_walk_reg;
    flash_on_next  = flash_on_reg;
    enter_walk     = 1'b0;
    case (state_reg)
      S_ALL_RED: begin
        if (timer_done) begin
          if (flash_en) begin
            state_next    = S_FLASH;
            timer_next    = FLASH_LD;
            flash_on_next = 1'b1;
          end else if (ped_pending_reg && !from_walk_reg) begin
            state_next = S_WALK;
            timer_next = WALK_LD;
            enter_walk = 1'b1;
          end else begin
            state_next   = S_GREEN;
            elapsed_next = '0;
          end
        end
      end
      S_GREEN: begin
        elapsed_next = elapsed_reg + TIMER_W'(1);
        if (elapsed_reg == GREEN_LAST || (ped_pending_reg && elapsed_reg >= MIN_LAST)) begin
          state_next = S_YELLOW;
          timer_next = YELLOW_LD;
        end
      end
      S_YELLOW: begin
        if (timer_done) begin
          state_next     = S_ALL_RED;
          timer_next     = ALLRED_LD;
          from_walk_next = 1'b0;
          phase_next     = (phase_reg == LAST_PHASE) ? '0 : phase_reg + PW'(1);
        end
      end
      S_WALK: begin
        if (timer_done) begin
          state_next     = S_ALL_RED;
          timer_next     = ALLRED_LD;
          from_walk_next = 1'b1;
        end
      end
      S_FLASH: begin
        // flash_en is only looked at on half-period boundaries
        if (timer_done) begin
          if (flash_en) begin
            timer_next    = FLASH_LD;
            flash_on_next = !flash_on_reg;
          end else begin
            state_next     = S_ALL_RED;
            timer_next     = ALLRED_LD;
            phase_next     = '0;
            from_walk_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = S_ALL_RED;
        timer_next = ALLRED_LD;
      end
    endcase
  end

  // Clearing on walk entry wins over a same-cycle button press
  always_comb begin
    ped_pending_next = ped_pending_reg;
    if (enter_walk)
      ped_pending_next = 1'b0;
    else if (ped_req && state_reg != S_WALK)
      ped_pending_next = 1'b1;
  end

  for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_lamp
    assign green[gi]  = (state_reg == S_GREEN) && (phase_reg == PW'(gi));
    assign yellow[gi] = ((state_reg == S_YELLOW) && (phase_reg == PW'(gi))) ||
                        ((state_reg == S_FLASH) && flash_on_reg);
    assign red[gi]    = (state_reg != S_FLASH) && !green[gi] && !yellow[gi];
  end

  assign walk        = (state_reg == S_WALK);
  assign ped_pending = ped_pending_reg;
  assign phase_idx   = phase_reg;

endmodule

// File: tb/tb_traffic_light_controller_multi.sv
// Directed table-driven bench for the 2-approach controller plus a 4-approach
// sweep/safety run on a second instance sharing the clock and reset.
module tb_traffic_light_controller_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [1:0] green, yellow, red;
  logic       walk, ped_pending;
  logic [0:0] phase_idx;

  logic       ped4 = 1'b0;
  logic       flash4 = 1'b0;
  logic [3:0] green4, yellow4, red4;
  logic       walk4, pend4;
  logic [1:0] phase4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  traffic_light_controller_multi dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .flash_en(flash_en),
    .green(green), .yellow(yellow), .red(red), .walk(walk),
    .ped_pending(ped_pending), .phase_idx(phase_idx)
  );

  traffic_light_controller_multi #(.NUM_DIR(4)) dut4 (
    .clk(clk), .rst(rst), .ped_req(ped4), .flash_en(flash4),
    .green(green4), .yellow(yellow4), .red(red4), .walk(walk4),
    .ped_pending(pend4), .phase_idx(phase4)
  );

  typedef struct {
    logic       rst, ped, flash;
    int         n;
    logic [1:0] g, y, r;
    logic       w, p, ph;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r_, input logic pd, input logic fl, input int n,
                     input logic [1:0] g, input logic [1:0] y, input logic [1:0] r,
                     input logic w, input logic p, input logic ph);
    vec_t v;
    v.rst = r_; v.ped = pd; v.flash = fl; v.n = n;
    v.g = g; v.y = y; v.r = r; v.w = w; v.p = p; v.ph = ph;
    tbl.push_back(v);
  endtask

  // Flash mode (red all 0) is exempt from the lamp-exclusivity rule
  function automatic bit safe_ok(input logic [7:0] g, input logic [7:0] y,
                                 input logic [7:0] r, input int n);
    if (r == 8'd0) return 1'b1;
    if ($countones(g | y) > 1) return 1'b0;
    for (int k = 0; k < n; k++)
      if ($countones({g[k], y[k], r[k]}) != 1) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [8:0] act, exp_v;
    logic [3:0] prev_g;
    int         want_dir, onsets;

    //   rst ped fl  n   green  yellow red   w  p  ph
    add(1, 0, 0, 3,  2'b00, 2'b00, 2'b11, 0, 0, 0);  // reset held
    add(0, 0, 0, 1,  2'b00, 2'b00, 2'b11, 0, 0, 0);
    add(0, 0, 0, 20, 2'b01, 2'b00, 2'b10, 0, 0, 0);
    add(0, 0, 0, 4,  2'b00, 2'b01, 2'b10, 0, 0, 0);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 0, 1);
    add(0, 0, 0, 20, 2'b10, 2'b00, 2'b01, 0, 0, 1);
    add(0, 0, 0, 4,  2'b00, 2'b10, 2'b01, 0, 0, 1);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 0, 0);
    add(0, 0, 0, 2,  2'b01, 2'b00, 2'b10, 0, 0, 0);  // early ped request
    add(0, 1, 0, 1,  2'b01, 2'b00, 2'b10, 0, 1, 0);
    add(0, 0, 0, 2,  2'b01, 2'b00, 2'b10, 0, 1, 0);
    add(0, 0, 0, 4,  2'b00, 2'b01, 2'b10, 0, 1, 0);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 1, 1);
    add(0, 0, 0, 10, 2'b00, 2'b00, 2'b11, 1, 0, 1);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 0, 1);
    add(0, 0, 0, 20, 2'b10, 2'b00, 2'b01, 0, 0, 1);
    add(0, 0, 0, 4,  2'b00, 2'b10, 2'b01, 0, 0, 1);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 0, 0);
    add(0, 0, 0, 15, 2'b01, 2'b00, 2'b10, 0, 0, 0);  // late ped request
    add(0, 1, 0, 1,  2'b01, 2'b00, 2'b10, 0, 1, 0);
    add(0, 0, 0, 4,  2'b00, 2'b01, 2'b10, 0, 1, 0);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 1, 1);
    add(0, 1, 0, 10, 2'b00, 2'b00, 2'b11, 1, 0, 1);  // button held during walk
    add(0, 0, 0, 1,  2'b00, 2'b00, 2'b11, 0, 0, 1);
    add(0, 1, 0, 1,  2'b00, 2'b00, 2'b11, 0, 1, 1);  // press in post-walk clearance
    add(0, 0, 0, 5,  2'b10, 2'b00, 2'b01, 0, 1, 1);
    add(0, 0, 0, 4,  2'b00, 2'b10, 2'b01, 0, 1, 1);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 1, 0);
    add(0, 0, 0, 10, 2'b00, 2'b00, 2'b11, 1, 0, 0);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 0, 0);
    add(0, 0, 0, 10, 2'b01, 2'b00, 2'b10, 0, 0, 0);
    add(0, 0, 1, 10, 2'b01, 2'b00, 2'b10, 0, 0, 0);  // flash request mid-green
    add(0, 0, 1, 4,  2'b00, 2'b01, 2'b10, 0, 0, 0);
    add(0, 0, 1, 2,  2'b00, 2'b00, 2'b11, 0, 0, 1);
    add(0, 0, 1, 8,  2'b00, 2'b11, 2'b00, 0, 0, 1);
    add(0, 0, 1, 8,  2'b00, 2'b00, 2'b00, 0, 0, 1);
    add(0, 0, 1, 3,  2'b00, 2'b11, 2'b00, 0, 0, 1);
    add(0, 0, 0, 5,  2'b00, 2'b11, 2'b00, 0, 0, 1);  // dropped mid half-period
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 0, 0);
    add(0, 0, 0, 20, 2'b01, 2'b00, 2'b10, 0, 0, 0);
    add(0, 0, 0, 4,  2'b00, 2'b01, 2'b10, 0, 0, 0);
    add(0, 0, 0, 2,  2'b00, 2'b00, 2'b11, 0, 0, 1);
    add(0, 0, 0, 6,  2'b10, 2'b00, 2'b01, 0, 0, 1);
    add(0, 1, 0, 1,  2'b10, 2'b00, 2'b01, 0, 1, 1);
    add(1, 0, 0, 1,  2'b00, 2'b00, 2'b11, 0, 0, 0);  // reset mid-green
    add(0, 0, 0, 1,  2'b00, 2'b00, 2'b11, 0, 0, 0);
    add(0, 0, 0, 3,  2'b01, 2'b00, 2'b10, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        rst = tbl[i].rst; ped_req = tbl[i].ped; flash_en = tbl[i].flash;
        @(posedge clk); #1;
        act   = {green, yellow, red, walk, ped_pending, phase_idx};
        exp_v = {tbl[i].g, tbl[i].y, tbl[i].r, tbl[i].w, tbl[i].p, tbl[i].ph};
        total++;
        if (act !== exp_v) begin
          bad++;
          $display("FAIL row%0d cyc%0d g/y/r/w/p/ph got=%b want=%b", i, c, act, exp_v);
        end
        $display("row%0d cyc%0d rst=%0b ped=%0b fl=%0b out=%b", i, c, rst, ped_req, flash_en, act);
      end
    end
    ped_req = 1'b0; flash_en = 1'b0;

    // Four-approach sweep with per-cycle safety checks
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prev_g = 4'd0; want_dir = 0; onsets = 0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1;
      total++;
      if (!safe_ok({4'd0, green4}, {4'd0, yellow4}, {4'd0, red4}, 4)) begin
        bad++;
        $display("FAIL safety4 t=%0d g=%b y=%b r=%b", t, green4, yellow4, red4);
      end
      if (green4 != 4'd0 && green4 != prev_g) begin
        total++;
        if (green4 !== 4'(1 << want_dir) || phase4 !== 2'(want_dir)) begin
          bad++;
          $display("FAIL sweep4 t=%0d got g=%b ph=%0d want dir=%0d", t, green4, phase4, want_dir);
        end
        $display("sweep4 t=%0d green=%b phase=%0d", t, green4, phase4);
        want_dir = (want_dir + 1) % 4;
        onsets++;
      end
      prev_g = green4;
    end
    total++;
    if (onsets < 5) begin
      bad++;
      $display("FAIL sweep4_count got=%0d want>=5", onsets);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety check on the two-approach instance every cycle of the table run
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (!safe_ok({6'd0, green}, {6'd0, yellow}, {6'd0, red}, 2)) begin
        bad++;
        $display("FAIL safety2 g=%b y=%b r=%b", green, yellow, red);
      end
    end
  end

endmodule
